// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define MDU_FAST_MULT_EN to compute multiplies in one cycle with a hardware multiplier.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [4:0]       aluctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic             done
);

  localparam logic [4:0] MULT_CONTROL  = 5'b11001;
  localparam logic [4:0] MULTU_CONTROL = 5'b11010;
  localparam logic [4:0] DIV_CONTROL   = 5'b11011;
  localparam logic [4:0] DIVU_CONTROL  = 5'b11100;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opd;
  logic                 op_div, neg_q, neg_r;

  logic                 is_mdu, is_div, is_signed, accept, div0;
  logic [WIDTH-1:0]     ma, mb;
  logic [WIDTH:0]       msum, trial;
  logic [2*WIDTH-1:0]   step, mres;
  logic [WIDTH-1:0]     qres, rres;

  always_comb begin
    is_mdu    = (aluctrl == MULT_CONTROL) || (aluctrl == MULTU_CONTROL) ||
                (aluctrl == DIV_CONTROL)  || (aluctrl == DIVU_CONTROL);
    is_div    = (aluctrl == DIV_CONTROL)  || (aluctrl == DIVU_CONTROL);
    is_signed = (aluctrl == MULT_CONTROL) || (aluctrl == DIV_CONTROL);
    accept    = (state == IDLE) && start && !flush && is_mdu;
    div0      = is_div && (b == '0);
    ma        = (is_signed && a[WIDTH-1]) ? -a : a;
    mb        = (is_signed && b[WIDTH-1]) ? -b : b;
  end

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fa, fb, fprod;
  // Sign-extending to 2*WIDTH lets one multiplier serve both MULT and MULTU.
  assign fa    = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
  assign fb    = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
  assign fprod = fa * fb;
`endif

  // acc holds {partial product} for multiply and {remainder, quotient} for divide.
  always_comb begin
    msum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd & {WIDTH{acc[0]}}};
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opd};
    if (!op_div)
      step = {msum, acc[WIDTH-1:1]};
    else if (trial[WIDTH])
      step = {acc[2*WIDTH-2:0], 1'b0};
    else
      step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    mres = neg_q ? -step : step;
    qres = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rres = neg_r ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (div0)
              state_nxt = DONE;
`ifdef MDU_FAST_MULT_EN
            else if (!is_div)
              state_nxt = DONE;
`endif
            else
              state_nxt = CALC;
          end
        end
        CALC:    if (cnt == LAST) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign stall = !rst && (((state == IDLE) && accept) || (state == CALC));
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      acc    <= '0;
      opd    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            op_div <= is_div;
            neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= is_signed && is_div && a[WIDTH-1];
            opd    <= is_div ? mb : ma;
            acc    <= {{WIDTH{1'b0}}, (is_div ? ma : mb)};
            if (div0) begin
              hi <= a;
              lo <= '1;
            end
`ifdef MDU_FAST_MULT_EN
            if (!is_div)
              {hi, lo} <= fprod;
`endif
          end else begin
            if (hilo_we[1]) hi <= hilo_wdata;
            if (hilo_we[0]) lo <= hilo_wdata;
          end
        end
        CALC: begin
          acc <= step;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            if (op_div) begin
              hi <= rres;
              lo <= qres;
            end else begin
              {hi, lo} <= mres;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table through a result scoreboard plus
// hand-built flush, reset and HI/LO write-port sequences.
module tb_mdu_iter;

  localparam logic [4:0] MULT_C  = 5'b11001;
  localparam logic [4:0] MULTU_C = 5'b11010;
  localparam logic [4:0] DIV_C   = 5'b11011;
  localparam logic [4:0] DIVU_C  = 5'b11100;
`ifdef MDU_FAST_MULT_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [4:0]  aluctrl;
  logic [31:0] a, b, hilo_wdata, hi, lo;
  logic [1:0]  hilo_we;
  logic        stall, done;

  mdu_iter #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .aluctrl(aluctrl),
    .a(a), .b(b), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
    .hi(hi), .lo(lo), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] a, b, ehi, elo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } res_t;

  vec_t vecs[13];
  res_t sbq[$];
  int   nchk = 0;
  int   nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // we0 drives hilo_we alongside start; we_cyc (>0) drives hilo_we=11 during that later cycle.
  task automatic issue(input string nm, input logic [4:0] ctrl, input logic [31:0] opa,
                       input logic [31:0] opb, input logic [31:0] ehi, input logic [31:0] elo,
                       input int lat, input logic [1:0] we0, input int we_cyc);
    logic [31:0] pre_hi, pre_lo;
    logic        got, stall_ok;
    int          cyc;
    res_t        r;
    @(posedge clk); #1;
    pre_hi = hi; pre_lo = lo;
    start = 1'b1; aluctrl = ctrl; a = opa; b = opb;
    hilo_we = we0; hilo_wdata = 32'hDEAD0000;
    sbq.push_back('{hi: ehi, lo: elo});
    @(negedge clk);
    chk({nm, "_stall_c0"}, {63'd0, stall}, 64'd1);
    got = 1'b0; stall_ok = 1'b1; cyc = 0;
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      hilo_we = (cyc == we_cyc) ? 2'b11 : 2'b00;
      hilo_wdata = 32'hBEEF0000;
      @(negedge clk);
      if (cyc == 1 && we0 != 2'b00 && !done)
        chk({nm, "_hilo_kept"}, {hi, lo}, {pre_hi, pre_lo});
      if (done) begin
        got = 1'b1;
        chk({nm, "_latency"}, 64'(cyc), 64'(lat));
        if (stall) stall_ok = 1'b0;
        if (sbq.size() == 0) begin
          chk({nm, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
          r = sbq.pop_front();
          chk({nm, "_hilo"}, {hi, lo}, {r.hi, r.lo});
        end
      end else if (!stall) begin
        stall_ok = 1'b0;
      end
    end
    hilo_we = 2'b00;
    if (!got) chk({nm, "_timeout"}, 64'd0, 64'd1);
    chk({nm, "_stall_window"}, {63'd0, stall_ok}, 64'd1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, {62'd0, done, stall}, 64'd0);
  endtask

  task automatic hilo_write(input logic [1:0] we, input logic [31:0] d);
    @(posedge clk); #1;
    hilo_we = we; hilo_wdata = d;
    @(posedge clk); #1;
    hilo_we = 2'b00;
  endtask

  // Starts a DIV, runs to cycle 10, then applies flush or async reset.
  task automatic abort_seq(input string nm, input logic use_rst);
    logic saw_done;
    @(posedge clk); #1;
    start = 1'b1; aluctrl = DIV_C; a = 32'd100; b = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (use_rst) begin
      rst = 1'b1;
      #1;
      chk({nm, "_hilo_now"}, {hi, lo}, 64'd0);
      chk({nm, "_stall_now"}, {62'd0, stall, done}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk({nm, "_stall_c11"}, {63'd0, stall}, 64'd0);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || stall) saw_done = 1'b1;
    end
    chk({nm, "_no_done"}, {63'd0, saw_done}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic saw;
    vecs[0]  = '{MULTU_C, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MLAT};
    vecs[1]  = '{MULT_C,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, MLAT};
    vecs[2]  = '{DIV_C,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{DIVU_C,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 33};
    vecs[4]  = '{DIVU_C,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1};
    vecs[5]  = '{MULTU_C, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MLAT};
    vecs[6]  = '{MULT_C,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MLAT};
    vecs[7]  = '{DIV_C,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[8]  = '{DIV_C,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 33};
    vecs[9]  = '{DIV_C,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[10] = '{DIV_C,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1};
    vecs[11] = '{MULT_C,  32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, MLAT};
    vecs[12] = '{DIVU_C,  32'h00000003, 32'h0000000A, 32'h00000003, 32'h00000000, 33};

    rst = 1'b1; start = 1'b0; flush = 1'b0; aluctrl = 5'd0;
    a = '0; b = '0; hilo_we = 2'b00; hilo_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {hi, lo}, 64'd0);
    chk("reset_ctl", {62'd0, stall, done}, 64'd0);
    rst = 1'b0;

    foreach (vecs[i])
      issue($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b,
            vecs[i].ehi, vecs[i].elo, vecs[i].lat, 2'b00, 0);

    // Idle LO-only write; HI still holds 0x00000003 from the last vector.
    hilo_write(2'b01, 32'h00001234);
    chk("mtlo", {hi, lo}, {32'h00000003, 32'h00001234});

    // Non-MDU code is ignored: no stall, no done, and the write port still works.
    @(posedge clk); #1;
    start = 1'b1; aluctrl = 5'b00010; hilo_we = 2'b10; hilo_wdata = 32'h0000AAAA;
    @(negedge clk);
    chk("ignored_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; hilo_we = 2'b00;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || stall) saw = 1'b1;
    end
    chk("ignored_no_done", {63'd0, saw}, 64'd0);
    chk("ignored_mthi", {hi, lo}, {32'h0000AAAA, 32'h00001234});

    // Write dropped alongside an accepting start and during CALC.
    issue("we_drop", DIVU_C, 32'd100, 32'd7, 32'd2, 32'd14, 33, 2'b11, 5);

    hilo_write(2'b10, 32'h0000AAAA);
    hilo_write(2'b01, 32'h00005555);
    chk("hilo_preset", {hi, lo}, {32'h0000AAAA, 32'h00005555});
    abort_seq("flush", 1'b0);
    chk("flush_hilo", {hi, lo}, {32'h0000AAAA, 32'h00005555});
    abort_seq("rst", 1'b1);
    chk("rst_hilo", {hi, lo}, 64'd0);

    // A clean operation after the aborts confirms the unit recovered.
    issue("post_abort", MULT_C, 32'h00000006, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6,
          MLAT, 2'b00, 0);
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
